// File: rtl/semafor_pkg.sv
// Shared types and timing defaults for the traffic-light sequencer.
// Timing constants are in whole seconds unless noted.
package semafor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVE   = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    localparam int CLK_HZ        = 12000;
    localparam int NRSTOP        = CLK_HZ;
    localparam int T_RED         = 10;
    localparam int T_GREEN       = 8;
    localparam int T_YELLOW      = 2;
    localparam int T_DELAY       = 1;
    localparam int DEF_LOCKOUT_S = 3;

    function automatic int secs_to_clk(int s);
        return s * NRSTOP;
    endfunction

    function automatic int cycle_s();
        return T_RED + T_GREEN + T_YELLOW + 2 * T_DELAY;
    endfunction

endpackage

// File: rtl/ped_request_unit_if.sv
// Button, sequencer handshake and status bundle of the pedestrian unit.
// master is the unit itself, slave is whoever drives the inputs.
interface ped_request_unit_if #(
    parameter int CNT_W = 8
);
    logic             button_raw;
    logic             tick_1s;
    logic             cycle_busy;
    logic             button_clean;
    logic             press_pulse;
    logic             request;
    logic             pending;
    logic             req_timeout;
    logic [CNT_W-1:0] press_count;
    logic [1:0]       state_dbg;

    modport master (
        input  button_raw, tick_1s, cycle_busy,
        output button_clean, press_pulse, request,
        output pending, req_timeout, press_count, state_dbg
    );

    modport slave (
        output button_raw, tick_1s, cycle_busy,
        input  button_clean, press_pulse, request,
        input  pending, req_timeout, press_count, state_dbg
    );
endinterface

// File: rtl/debounce_sync.sv
// Synchroniser, debounce counter and rising-edge detect for the button.
// button_clean only follows a level held for DEBOUNCE_CYCLES clocks.
module debounce_sync #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 120
) (
    input  logic clk,
    input  logic rst,
    input  logic button_raw,
    output logic button_clean,
    output logic press_pulse
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sr;
    logic                   sync;
    logic                   clean;
    logic                   clean_d;
    logic [DW-1:0]          cnt;

    assign sync = sr[SYNC_STAGES-1];

    // Shift the asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sr <= '0;
        else      sr <= {sr[SYNC_STAGES-2:0], button_raw};
    end

    // Count how long sync has disagreed with clean; flip clean when held long enough.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            clean <= 1'b0;
        end else if (sync == clean) begin
            cnt   <= '0;
        end else if (cnt == DB_LAST) begin
            cnt   <= '0;
            clean <= ~clean;
        end else begin
            cnt   <= cnt + DW'(1);
        end
    end

    // Delayed copy of clean for the press edge detect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) clean_d <= 1'b0;
        else      clean_d <= clean;
    end

    assign button_clean = clean;
    assign press_pulse  = clean & ~clean_d;
endmodule

// File: rtl/ped_request_unit.sv
// Pedestrian request unit: debounced presses become a req/busy handshake
// with press latching during a cycle and a lockout gap between cycles.
module ped_request_unit
    import semafor_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 120,
    parameter int LOCKOUT_S       = DEF_LOCKOUT_S,
    parameter int REQ_TIMEOUT_S   = 5,
    parameter int CNT_W           = 8
) (
    input logic                clk,
    input logic                rst,
    ped_request_unit_if.master bus
);
    localparam int TMAX = (LOCKOUT_S > REQ_TIMEOUT_S) ? LOCKOUT_S : REQ_TIMEOUT_S;
    localparam int TW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);
    localparam logic [TW-1:0] LOCK_N = TW'(LOCKOUT_S);
    localparam logic [TW-1:0] TOUT_N = TW'(REQ_TIMEOUT_S);

    state_t           state;
    state_t           nxt;
    logic             pend;
    logic             pend_nxt;
    logic             tout;
    logic             tout_nxt;
    logic [TW-1:0]    tcnt;
    logic [CNT_W-1:0] cnt;
    logic             clean;
    logic             pulse;
    logic             busy;
    logic             tick_en;

    assign busy = bus.cycle_busy;

    debounce_sync #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
        .clk          (clk),
        .rst          (rst),
        .button_raw   (bus.button_raw),
        .button_clean (clean),
        .press_pulse  (pulse)
    );

    // State, pending latch and sticky timeout flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            pend  <= 1'b0;
            tout  <= 1'b0;
        end else begin
            state <= nxt;
            pend  <= pend_nxt;
            tout  <= tout_nxt;
        end
    end

    // Next state; busy always takes priority over timeout and lockout exit.
    always_comb begin
        nxt      = state;
        pend_nxt = pend;
        tout_nxt = tout;
        unique case (state)
            IDLE: begin
                if (pulse) pend_nxt = 1'b1;
                if (busy)       nxt = SERVE;
                else if (pulse) nxt = REQ;
            end
            REQ: begin
                if (busy) begin
                    nxt      = SERVE;
                    pend_nxt = 1'b0;
                end else if (tcnt == TOUT_N) begin
                    nxt      = IDLE;
                    pend_nxt = 1'b0;
                    tout_nxt = 1'b1;
                end
            end
            SERVE: begin
                if (pulse) pend_nxt = 1'b1;
                if (!busy) nxt = LOCKOUT;
            end
            LOCKOUT: begin
                if (pulse) pend_nxt = 1'b1;
                if (busy)                nxt = SERVE;
                else if (tcnt == LOCK_N) nxt = (pend | pulse) ? REQ : IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    assign tick_en = bus.tick_1s &&
                     (((state == REQ) && (tcnt != TOUT_N)) ||
                      ((state == LOCKOUT) && (tcnt != LOCK_N)));

    // Seconds counter, cleared on every state change and saturating at its limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              tcnt <= '0;
        else if (nxt != state) tcnt <= '0;
        else if (tick_en)      tcnt <= tcnt + TW'(1);
    end

    // Count every debounced press, wrapping naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       cnt <= '0;
        else if (pulse) cnt <= cnt + CNT_W'(1);
    end

    assign bus.button_clean = clean;
    assign bus.press_pulse  = pulse;
    assign bus.request      = (state == REQ);
    assign bus.pending      = pend;
    assign bus.req_timeout  = tout;
    assign bus.press_count  = cnt;
    assign bus.state_dbg    = state;
endmodule
